// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a synchronous flush.
// With SKID=1 a second (skid) slot absorbs the entry that arrives in the cycle
// downstream stalls. This lets in_ready_o come straight from a flop instead of
// from out_ready_i.
// With SKID=0 the stage holds a single entry and in_ready_o is combinational.
//
// state | meaning
// EMPTY | no entry held, output slot invalid
// ONE   | output slot (main) valid, skid slot empty
// FULL  | main and skid both valid, upstream back-pressured (SKID=1 only)
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W     = 64,
  parameter bit          SKID       = 1'b1,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = (state_q == FULL) ? 2'd2 :
                       (state_q == ONE)  ? 2'd1 : 2'd0;

  // Skid variant: ready is a flop, so out_ready_i never feeds back upstream.
  assign in_ready_o  = SKID ? in_ready_q : (~out_valid_o | out_ready_i);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  // Next-state and data steering; flush overrides everything the handshake decided.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          // Only reachable with SKID=1; with SKID=0 in_ready implies out_ready here.
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end
    in_ready_d = (state_d != FULL);
  end

  // State, payload and registered ready update; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl1, iv1, or1, ir1, ov1;
  logic [63:0] id1, od1;
  logic [1:0]  oc1;
  logic        fl0, iv0, or0, ir0, ov0;
  logic [63:0] id0, od0;
  logic [1:0]  oc0;

  int checks = 0;
  int failures = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(64), .SKID(1'b1), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(fl1), .in_valid_i(iv1), .in_ready_o(ir1),
    .in_data_i(id1), .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
    .occupancy_o(oc1));

  pipe_stage_skid_reg #(.DATA_W(64), .SKID(1'b0), .CLEAR_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush_i(fl0), .in_valid_i(iv0), .in_ready_o(ir0),
    .in_data_i(id0), .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0),
    .occupancy_o(oc0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO queues of held entries; pushed on accepted input, popped on output.
  always @(posedge clk or posedge rst) begin
    logic rdy, ifire, ofire;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      rdy   = (q1.size() != 2);
      ifire = iv1 && rdy;
      ofire = (q1.size() > 0) && or1;
      if (fl1) q1.delete();
      else begin
        if (ofire) void'(q1.pop_front());
        if (ifire) q1.push_back(id1);
      end
      rdy   = (q0.size() == 0) || or0;
      ifire = iv0 && rdy;
      ofire = (q0.size() > 0) && or0;
      if (fl0) q0.delete();
      else begin
        if (ofire) void'(q0.pop_front());
        if (ifire) q0.push_back(id0);
      end
    end
  end

  // Compare both stages to the model every cycle, mid-cycle with inputs settled.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sb1_out_valid", {63'd0, ov1}, {63'd0, q1.size() > 0});
      chk("sb1_occupancy", {62'd0, oc1}, 64'(q1.size()));
      chk("sb1_in_ready", {63'd0, ir1}, {63'd0, q1.size() != 2});
      if (q1.size() > 0) chk("sb1_out_data", od1, q1[0]);
      chk("sb0_out_valid", {63'd0, ov0}, {63'd0, q0.size() > 0});
      chk("sb0_occupancy", {62'd0, oc0}, 64'(q0.size()));
      chk("sb0_in_ready", {63'd0, ir0}, {63'd0, (q0.size() == 0) || or0});
      if (q0.size() > 0) chk("sb0_out_data", od0, q0[0]);
    end
  end

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic        cd;
    logic [1:0]  eo;
    logic        er;
  } vec_t;

  function automatic vec_t mkv(logic fl, logic iv, logic [63:0] id, logic ordy,
                               logic ev, logic [63:0] ed, logic cd, logic [1:0] eo, logic er);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.cd = cd; v.eo = eo; v.er = er;
    return v;
  endfunction

  localparam logic [63:0] A = 64'hA0A0_0000_0000_000A;
  localparam logic [63:0] B = 64'hB0B0_0000_0000_000B;
  localparam logic [63:0] C = 64'hC0C0_0000_0000_000C;
  localparam logic [63:0] D = 64'hD0D0_0000_0000_000D;
  localparam logic [63:0] E = 64'hE0E0_0000_0000_000E;
  localparam logic [63:0] F = 64'hF0F0_0000_0000_000F;
  localparam logic [63:0] G = 64'h6060_0000_0000_0006;
  localparam logic [63:0] H = 64'h7070_0000_0000_0007;
  localparam logic [63:0] BASE = 64'h1000_0000_0000_0001;

  vec_t tv[13];

  initial begin
    // expected values are the SKID=1 stage outputs right after the edge
    tv[0]  = mkv(0, 1, A, 1,  1, A,    1, 2'd1, 1);
    tv[1]  = mkv(0, 1, B, 0,  1, A,    1, 2'd2, 0);
    tv[2]  = mkv(0, 1, C, 0,  1, A,    1, 2'd2, 0);
    tv[3]  = mkv(0, 1, C, 1,  1, B,    1, 2'd1, 1);
    tv[4]  = mkv(0, 1, C, 1,  1, C,    1, 2'd1, 1);
    tv[5]  = mkv(0, 0, 0, 1,  0, 0,    0, 2'd0, 1);
    tv[6]  = mkv(0, 1, D, 0,  1, D,    1, 2'd1, 1);
    tv[7]  = mkv(0, 1, E, 0,  1, D,    1, 2'd2, 0);
    tv[8]  = mkv(1, 1, F, 0,  0, 64'd0, 1, 2'd0, 1);
    tv[9]  = mkv(0, 0, 0, 0,  0, 64'd0, 1, 2'd0, 1);
    tv[10] = mkv(0, 1, G, 0,  1, G,    1, 2'd1, 1);
    tv[11] = mkv(1, 0, 0, 1,  0, 64'd0, 1, 2'd0, 1);
    tv[12] = mkv(0, 1, H, 1,  1, H,    1, 2'd1, 1);

    rst = 1'b1;
    fl1 = 0; iv1 = 0; or1 = 0; id1 = '0;
    fl0 = 0; iv0 = 0; or0 = 0; id0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid1", {63'd0, ov1}, 64'd0);
    chk("rst_out_data1", od1, 64'd0);
    chk("rst_occ1", {62'd0, oc1}, 64'd0);
    chk("rst_in_ready1", {63'd0, ir1}, 64'd1);
    chk("rst_in_ready0", {63'd0, ir0}, 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      fl1 = tv[i].fl; iv1 = tv[i].iv; id1 = tv[i].id; or1 = tv[i].ordy;
      tick();
      chk($sformatf("vec%0d_out_valid", i), {63'd0, ov1}, {63'd0, tv[i].ev});
      chk($sformatf("vec%0d_occ", i), {62'd0, oc1}, {62'd0, tv[i].eo});
      chk($sformatf("vec%0d_in_ready", i), {63'd0, ir1}, {63'd0, tv[i].er});
      if (tv[i].cd) chk($sformatf("vec%0d_out_data", i), od1, tv[i].ed);
    end
    fl1 = 0; iv1 = 0; or1 = 1;
    tick();

    // back-to-back stream, one-cycle latency, no bubbles
    for (int i = 0; i < 8; i++) begin
      iv1 = 1; id1 = BASE + 64'(i); or1 = 1;
      tick();
      chk($sformatf("stream%0d_valid", i), {63'd0, ov1}, 64'd1);
      chk($sformatf("stream%0d_data", i), od1, BASE + 64'(i));
    end
    iv1 = 0;
    tick();

    // single-entry stage: ready follows out_ready combinationally
    iv0 = 1; id0 = A; or0 = 1;
    tick();
    chk("s0_first_data", od0, A);
    iv0 = 1; id0 = B; or0 = 0;
    #1;
    chk("s0_stall_in_ready", {63'd0, ir0}, 64'd0);
    tick();
    chk("s0_stall_hold", od0, A);
    chk("s0_stall_occ", {62'd0, oc0}, 64'd1);
    or0 = 1;
    #1;
    chk("s0_release_in_ready", {63'd0, ir0}, 64'd1);
    tick();
    chk("s0_pass_data", od0, B);
    iv0 = 0;
    tick();
    chk("s0_drained", {63'd0, ov0}, 64'd0);

    // asynchronous reset while both stages hold entries
    iv1 = 1; id1 = C; or1 = 0; iv0 = 1; id0 = D; or0 = 0;
    tick();
    id1 = E;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid1", {63'd0, ov1}, 64'd0);
    chk("midrst_data1", od1, 64'd0);
    chk("midrst_occ1", {62'd0, oc1}, 64'd0);
    chk("midrst_ready1", {63'd0, ir1}, 64'd1);
    chk("midrst_valid0", {63'd0, ov0}, 64'd0);
    chk("midrst_data0", od0, 64'd0);
    iv1 = 0; iv0 = 0;
    tick();
    rst = 1'b0;
    tick();

    // random traffic on both stages against the reference model
    for (int n = 0; n < 10000; n++) begin
      iv1 = ($urandom % 4) != 0;
      or1 = ($urandom % 3) != 0;
      fl1 = ($urandom % 50) == 0;
      id1 = {$urandom, $urandom};
      iv0 = ($urandom % 4) != 0;
      or0 = ($urandom % 3) != 0;
      fl0 = ($urandom % 50) == 0;
      id0 = {$urandom, $urandom};
      tick();
    end
    iv1 = 0; fl1 = 0; or1 = 1;
    iv0 = 0; fl0 = 0; or0 = 1;
    repeat (3) tick();
    chk("final_empty1", {63'd0, ov1}, 64'd0);
    chk("final_empty0", {63'd0, ov0}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
